// File: rtl/countdown_bcd_if.sv
// Control and display bundle between the phase controller and the
// two-digit BCD countdown timer.
interface countdown_bcd_if;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       pause;
  logic       clear;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       expired;

  modport master (
    output load, load_tens, load_ones, pause, clear,
    input  tens, ones, running, expired
  );

  modport slave (
    input  load, load_tens, load_ones, pause, clear,
    output tens, ones, running, expired
  );
endinterface

// File: rtl/countdown_bcd.sv
// Two-digit BCD phase countdown: loads 00-99, steps down once per prescaled
// tick, blanks the display (4'hF) when idle and pulses expired on reaching 00.
module countdown_bcd #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  countdown_bcd_if.slave io_cd
);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [3:0]    r_tens, w_tens_nxt;
  logic [3:0]    r_ones, w_ones_nxt;
  logic          r_running;
  logic          r_expired, w_expired_nxt;
  logic [3:0]    w_ld_tens, w_ld_ones;
  logic          w_tick;
  logic          w_dec_zero;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    clamp_bcd = (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign w_ld_tens  = clamp_bcd(io_cd.load_tens);
  assign w_ld_ones  = clamp_bcd(io_cd.load_ones);
  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_dec_zero = (r_tens == 4'd0) && (r_ones == 4'd1);

  // State, prescaler and all display/status outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_tens    <= 4'hF;
      r_ones    <= 4'hF;
      r_running <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_tens    <= w_tens_nxt;
      r_ones    <= w_ones_nxt;
      r_running <= (w_state_nxt == S_RUN) || (w_state_nxt == S_HOLD);
      r_expired <= w_expired_nxt;
    end
  end

  // Next-state logic: clear beats load; pause freezes both digits and prescaler.
  always_comb begin
    w_state_nxt   = r_state;
    w_presc_nxt   = r_presc;
    w_tens_nxt    = r_tens;
    w_ones_nxt    = r_ones;
    w_expired_nxt = 1'b0;
    if (io_cd.clear) begin
      w_state_nxt = S_IDLE;
      w_presc_nxt = '0;
      w_tens_nxt  = 4'hF;
      w_ones_nxt  = 4'hF;
    end else if (io_cd.load) begin
      w_presc_nxt = '0;
      w_tens_nxt  = w_ld_tens;
      w_ones_nxt  = w_ld_ones;
      if ((w_ld_tens == 4'd0) && (w_ld_ones == 4'd0)) begin
        w_state_nxt   = S_DONE;
        w_expired_nxt = 1'b1;
      end else begin
        w_state_nxt = S_RUN;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          w_tens_nxt = 4'hF;
          w_ones_nxt = 4'hF;
        end
        S_RUN: begin
          if (io_cd.pause) begin
            w_state_nxt = S_HOLD;
          end else if (w_tick) begin
            w_presc_nxt = '0;
            if (r_ones != 4'd0) begin
              w_ones_nxt = r_ones - 4'd1;
            end else begin
              w_ones_nxt = 4'd9;
              w_tens_nxt = r_tens - 4'd1;
            end
            if (w_dec_zero) begin
              w_state_nxt   = S_DONE;
              w_expired_nxt = 1'b1;
            end else begin
              w_state_nxt = S_RUN;
            end
          end else begin
            w_presc_nxt = r_presc + PW'(1);
          end
        end
        S_HOLD: begin
          if (!io_cd.pause) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
        S_DONE: begin
          w_tens_nxt = 4'd0;
          w_ones_nxt = 4'd0;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_presc_nxt = '0;
          w_tens_nxt  = 4'hF;
          w_ones_nxt  = 4'hF;
        end
      endcase
    end
  end

  assign io_cd.tens    = r_tens;
  assign io_cd.ones    = r_ones;
  assign io_cd.running = r_running;
  assign io_cd.expired = r_expired;
endmodule
